// File: rtl/disp_pkg.sv
// Shared definitions for the board display scan controller.
package disp_pkg;

    localparam int          CODE_W     = 5;
    localparam logic [4:0]  CHAR_NULL  = 5'b10000;
    localparam logic [4:0]  CHAR_POINT = 5'b10001;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/msg_buffer.sv
// Message register file: synchronous write, asynchronous read, resets to buffer[i] = i.
module msg_buffer
    import disp_pkg::*;
#(
    parameter int MSG_LEN = 16,
    parameter int AW      = $clog2(MSG_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CODE_W-1:0] rd_data
);

    logic [CODE_W-1:0] mem_q [MSG_LEN];

    // Storage: identity pattern on reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= CODE_W'(i);
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read is combinational, so a same-cycle write is not seen until the next cycle.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan scheduler for the shared 7-segment decoder with a scrolling 16-entry message.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_BLANK | first BLANK_CYCLES clocks of a digit slot, all anodes off
//  ST_DRIVE | rest of the slot, one anode on, its character on char_code
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int MSG_LEN      = 16,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int SHIFT_DIV    = 25000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       msg_wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] msg_wr_addr,
    input  logic [CODE_W-1:0]          msg_wr_data,
    input  logic                       pause,
    input  logic                       step,
    output logic [DIGITS-1:0]          anode,
    output logic [CODE_W-1:0]          char_code,
    output logic [$clog2(MSG_LEN)-1:0] msg_offset
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SHIFT_DIV);

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] BLANK_N    = RW'(BLANK_CYCLES);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_DIV - 1);

    scan_state_t       state_q, state_d;
    logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [SW-1:0]     shift_cnt_q, shift_cnt_d;
    logic              pending_q, pending_d;
    logic [AW-1:0]     offset_q, offset_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic [CODE_W-1:0] char_q, char_d;

    logic              ref_wrap;
    logic              frame_end;
    logic              shift_wrap;
    logic [AW-1:0]     rd_idx;
    logic [CODE_W-1:0] rd_data;

    msg_buffer #(
        .MSG_LEN (MSG_LEN),
        .AW      (AW)
    ) u_msg_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (msg_wr_en),
        .wr_addr (msg_wr_addr),
        .wr_data (msg_wr_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // Slot/digit counters, scroll timer and tear-free offset update.
    always_comb begin
        ref_wrap    = (ref_cnt_q == REF_LAST);
        frame_end   = ref_wrap && (digit_q == 2'd0);
        ref_cnt_d   = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        digit_d     = ref_wrap ? digit_q - 2'd1 : digit_q;
        shift_wrap  = 1'b0;
        shift_cnt_d = shift_cnt_q;
        if (!pause) begin
            shift_wrap  = (shift_cnt_q == SHIFT_LAST);
            shift_cnt_d = shift_wrap ? '0 : shift_cnt_q + 1'b1;
        end
        offset_d  = offset_q + AW'(pending_q && frame_end);
        pending_d = (pending_q && !frame_end) || step || shift_wrap;
    end

    // Character index for the digit about to be shown: offset + (3 - digit).
    assign rd_idx = offset_d + {{(AW-2){1'b0}}, ~digit_d};

    // Scan FSM next state and the registered output values that go with it.
    always_comb begin
        state_d = state_q;
        anode_d = '1;
        char_d  = CHAR_NULL;
        case (state_q)
            ST_BLANK: if (ref_cnt_d >= BLANK_N) state_d = ST_DRIVE;
            ST_DRIVE: if (ref_cnt_d == '0)      state_d = ST_BLANK;
            default:                            state_d = ST_BLANK;
        endcase
        if (state_d == ST_DRIVE) begin
            anode_d = ~(DIGITS'(1) << digit_d);
            char_d  = rd_data;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BLANK;
            ref_cnt_q   <= '0;
            digit_q     <= 2'd3;
            shift_cnt_q <= '0;
            pending_q   <= 1'b0;
            offset_q    <= '0;
            anode_q     <= '1;
            char_q      <= CHAR_NULL;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            digit_q     <= digit_d;
            shift_cnt_q <= shift_cnt_d;
            pending_q   <= pending_d;
            offset_q    <= offset_d;
            anode_q     <= anode_d;
            char_q      <= char_d;
        end
    end

    assign anode      = anode_q;
    assign char_code  = char_q;
    assign msg_offset = offset_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: cycle-level reference model of the display timeline.
module tb_display_scan_ctrl;

    localparam int REF   = 8;
    localparam int BLANK = 2;
    localparam int SDIV  = 64;
    localparam int FRAME = 4 * REF;

    logic       clk = 1'b0;
    logic       reset;
    logic       msg_wr_en;
    logic [3:0] msg_wr_addr;
    logic [4:0] msg_wr_data;
    logic       pause;
    logic       step;
    logic [3:0] anode;
    logic [4:0] char_code;
    logic [3:0] msg_offset;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DIGITS       (4),
        .MSG_LEN      (16),
        .REFRESH_DIV  (REF),
        .BLANK_CYCLES (BLANK),
        .SHIFT_DIV    (SDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .msg_wr_en   (msg_wr_en),
        .msg_wr_addr (msg_wr_addr),
        .msg_wr_data (msg_wr_data),
        .pause       (pause),
        .step        (step),
        .anode       (anode),
        .char_code   (char_code),
        .msg_offset  (msg_offset)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: t = clocks since reset, sc = scroll timer, buffers as seen now and as seen by the last read.
    int t, sc, off;
    bit pend;
    int mbuf[16];
    int mbuf_rd[16];
    bit cur_pause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; sc = 0; off = 0; pend = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mbuf[i]    = i;
            mbuf_rd[i] = i;
        end
    endtask

    task automatic check_outputs();
        int r, d;
        logic [31:0] ea, ec;
        r = t % REF;
        d = 3 - ((t / REF) % 4);
        if (r < BLANK) begin
            ea = 32'hF;
            ec = 32'h10;
        end else begin
            ea = 32'hF ^ (32'd1 << d);
            ec = 32'(mbuf_rd[(off + 3 - d) % 16]);
        end
        chk("anode", {28'd0, anode}, ea);
        chk("char_code", {27'd0, char_code}, ec);
        chk("msg_offset", {28'd0, msg_offset}, 32'(off));
    endtask

    // Check this cycle, apply inputs, advance the model, move to the next cycle.
    task automatic cycle(input bit rst, input bit we, input int wa, input int wd,
                         input bit p, input bit s);
        bit frame_last, wrap;
        check_outputs();
        reset       = rst;
        msg_wr_en   = we;
        msg_wr_addr = 4'(wa);
        msg_wr_data = 5'(wd);
        pause       = p;
        step        = s;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 16; i++) mbuf_rd[i] = mbuf[i];
            if (we) mbuf[wa % 16] = wd % 32;
            frame_last = ((t % FRAME) == FRAME - 1);
            wrap = !p && (sc == SDIV - 1);
            if (!p) sc = (sc + 1) % SDIV;
            if (pend && frame_last) off = (off + 1) % 16;
            pend = (pend && !frame_last) || s || wrap;
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit p);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, p, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    // Step once per frame (paused) until the model offset reaches target.
    task automatic step_to(input int target);
        for (int i = 0; i < 40 * FRAME && off != target; i++) begin
            cycle(1'b0, 1'b0, 0, 0, 1'b1, (t % FRAME) == 5);
        end
        chk("step_to_offset", {28'd0, msg_offset}, 32'(target));
    endtask

    initial begin
        reset = 1'b1; msg_wr_en = 1'b0; msg_wr_addr = '0; msg_wr_data = '0;
        pause = 1'b1; step = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Paused scan sequence, two full frames.
        idle(2 * FRAME, 1'b1);

        // Free-running scroll over several timer periods.
        idle(4 * SDIV, 1'b0);

        // Three step pulses inside one frame.
        do_reset();
        idle(3, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        idle(4, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        idle(9, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        idle(2 * FRAME, 1'b1);
        chk("three_steps_once", {28'd0, msg_offset}, 32'd1);

        // Write POINT into addr 2 while digit 1 is driven at offset 0.
        do_reset();
        idle(19, 1'b1);
        cycle(1'b0, 1'b1, 2, 5'b10001, 1'b1, 1'b0);
        idle(FRAME + 8, 1'b1);

        // Reset mid-drive of digit 2 at offset 7 with a request pending.
        step_to(7);
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != 10; i++) idle(1, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        chk("reset_anode", {28'd0, anode}, 32'hF);
        chk("reset_char", {27'd0, char_code}, 32'h10);
        chk("reset_offset", {28'd0, msg_offset}, 32'd0);
        idle(2 * FRAME, 1'b1);

        // Wrap across the buffer end: offsets 13 and 15.
        step_to(13);
        idle(FRAME, 1'b1);
        step_to(15);
        idle(2 * FRAME, 1'b1);

        // Randomized traffic including undefined codes and occasional resets.
        cur_pause = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) cur_pause = ~cur_pause;
            cycle($urandom_range(399) == 0,
                  $urandom_range(7) == 0,
                  int'($urandom_range(15)),
                  int'($urandom_range(31)),
                  cur_pause,
                  $urandom_range(39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
